audiogen_multich: RTL
=====================

// Module: audiogen_multich
// PURPOSE
//  Multi-channel square-wave tone and LFSR noise generator for TT audio/LED projects.
//  It is the parametrised successor of the single-tone, single-noise generator.
//  Fully synchronous: no derived clocks and no ripple dividers.
//  A shared prescaler drives NUM_CH programmable tone channels and one noise channel.
//  A registered mixer sums the enabled channel outputs into a level output.
//  Configured through a simple write-only register port driven by the ui_in/uio_in glue.
// PARAMETERS
//  NUM_CH    4     number of tone channels (1..8)
//  PERIOD_W  10    tone half-period register width; must be >= NUM_CH+1
//  PRESCALE  64    clk cycles per prescaler tick (>=2)
// PORTS
//  clk        in   1                  single system clock
//  rst        in   1                  synchronous, active-high reset
//  cfg_we     in   1                  register write strobe (1 cycle)
//  cfg_addr   in   $clog2(NUM_CH+2)   register address
//  cfg_wdata  in   PERIOD_W           write data
//  tone_out   out  NUM_CH             per-channel square waves (registered)
//  noise_out  out  1                  LFSR noise bit (registered)
//  mix_level  out  $clog2(NUM_CH+2)   count of enabled channels currently high
// BEHAVIOUR
//  Reset: every register and output is cleared on the clk edge where rst=1.
//   - Cleared values: tone_out=0, noise_out=0, mix_level=0, periods=0, enables=0, noise_rate=0.
//   - The LFSR loads LFSR_SEED. Reset mid-operation aborts all counting immediately.
//  Register map (writes take effect the cycle after cfg_we):
//   - addr 0..NUM_CH-1: period[i].
//   - addr NUM_CH: ctrl. [NUM_CH-1:0]=tone_en, [NUM_CH]=noise_en.
//   - addr NUM_CH+1: noise_rate, taken from [3:0].
//   - Writes to any other address are ignored.
//  Prescaler: counts 0..PRESCALE-1 and wraps. tick=1 for one clk when count==PRESCALE-1.
//  Tone channel i, evaluated only on tick:
//   - If tone_en[i]=0 or period[i]==0: cnt<=0 and tone_out[i]<=0 (muted).
//   - Else if cnt==0: cnt<=period[i] and tone_out[i] toggles.
//   - Else: cnt<=cnt-1.
//   - Half-period = period+1 ticks, so f = f_clk / (2*PRESCALE*(period+1)).
//  A period write is picked up only at the next reload, so the output never glitches.
//  A write and a reload in the same cycle: the reload uses the old period.
//  A disabling ctrl write on a tick cycle: the disable wins and tone_out[i]=0 the next cycle.
//  Noise channel:
//   - ncnt counts ticks. On the tick where ncnt==(2^noise_rate)-1, ncnt<=0 and the LFSR shifts once.
//   - LFSR is 16-bit Fibonacci with taps 16,14,13,11. noise_out = lfsr[0] when noise_en=1, else 0.
//   - If the LFSR state is ever all-zero, the next shift loads LFSR_SEED (lockup recovery).
//  mix_level: registered popcount of tone_out plus noise_out.
//   - It lags the channel outputs by 1 clk. Muted channels contribute 0.
// CONFIGURATION
//  AUDIOGEN_NOISE_EN defined: the noise channel, noise_rate register and ctrl bit NUM_CH exist.
//  AUDIOGEN_NOISE_EN undefined:
//   - The LFSR logic is not built.
//   - noise_out is tied to 0.
//   - Address NUM_CH+1 and ctrl bit NUM_CH are ignored.
//   - mix_level counts tone channels only. Port list is unchanged.
// STRUCTURE
//  Package audiogen_pkg holds:
//   - LFSR_W=16, LFSR_SEED=16'hACE1, LFSR_TAPS mask.
//   - Address helpers ADDR_CTRL(n)=n and ADDR_NRATE(n)=n+1.
//  Sub-module audiogen_tone_ch: one tone channel (period input, en, tick -> tone_out).
//  It is instantiated NUM_CH times in a generate loop.
//  The top level holds the prescaler, the register file, the noise channel and the mixer.
// TESTING
//  1. NUM_CH=4, PRESCALE=4. Write period[0]=3 and ctrl=0x01.
//     -> tone_out[0] toggles every 16 clk (period 32 clk). Other channels stay 0.
//  2. Rewrite period[0]=1 mid half-period.
//     -> The current half-period finishes with 4 ticks, then half-periods are 2 ticks. No short pulse.
//  3. period[1]=0 with tone_en[1]=1 -> tone_out[1] stays 0 and mix_level never counts it.
//  4. Enable all 4 tones with equal periods.
//     -> mix_level alternates 0 and 4, one clk after the tone_out edges.
//  5. noise_en=1, noise_rate=0, PRESCALE=4.
//     -> The LFSR shifts every 4 clk. The first 8 noise_out values match the reference model seeded 0xACE1.
//  6. Assert rst for 1 clk while channels are running.
//     -> On the next clk all outputs are 0 and LFSR=0xACE1. Behaviour then restarts as from power-up.

Source files
------------

// File: rtl/audiogen_pkg.sv
// Shared constants and helpers for the multi-channel audio generator.
// The optional noise channel is built only when AUDIOGEN_NOISE_EN is defined.
package audiogen_pkg;

   localparam int unsigned LFSR_W  = 16;
   localparam int unsigned NRATE_W = 4;
   // Wide enough to hold (2^15)-1, the longest noise divider.
   localparam int unsigned NCNT_W  = 16;

   localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
   // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR map to bits 0,2,3,5.
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

   // Address of the control register for an n-channel build.
   function automatic int unsigned ADDR_CTRL(input int unsigned n);
      return n;
   endfunction

   // Address of the noise-rate register for an n-channel build.
   function automatic int unsigned ADDR_NRATE(input int unsigned n);
      return n + 1;
   endfunction

   // One LFSR shift; an all-zero state recovers to the seed.
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      if (s == '0) begin
         return LFSR_SEED;
      end
      return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
   endfunction

endpackage

// File: rtl/audiogen_tone_ch.sv
// One square-wave tone channel: toggles every period+1 prescaler ticks.
module audiogen_tone_ch #(
   parameter int unsigned PERIOD_W = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                tick,
   input  logic                en,
   input  logic [PERIOD_W-1:0] period,
   output logic                tone_out
);

   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic                tone_q, tone_d;

   // Half-period countdown; the period is sampled only at reload so edits never glitch.
   always_comb begin
      cnt_d  = cnt_q;
      tone_d = tone_q;
      if (tick) begin
         if (!en || (period == '0)) begin
            cnt_d  = '0;
            tone_d = 1'b0;
         end else if (cnt_q == '0) begin
            cnt_d  = period;
            tone_d = ~tone_q;
         end else begin
            cnt_d  = cnt_q - PERIOD_W'(1);
         end
      end
   end

   // Channel state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         tone_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tone_q <= tone_d;
      end
   end

   assign tone_out = tone_q;

endmodule

// File: rtl/audiogen_multich.sv
// Multi-channel tone + LFSR noise generator with a registered level mixer.
// Define AUDIOGEN_NOISE_EN to build the noise channel and its registers.
module audiogen_multich
   import audiogen_pkg::*;
#(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned PERIOD_W = 10,
   parameter int unsigned PRESCALE = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cfg_we,
   input  logic [$clog2(NUM_CH+2)-1:0]   cfg_addr,
   input  logic [PERIOD_W-1:0]           cfg_wdata,
   output logic [NUM_CH-1:0]             tone_out,
   output logic                          noise_out,
   output logic [$clog2(NUM_CH+2)-1:0]   mix_level
);

   localparam int unsigned ADDR_W = $clog2(NUM_CH + 2);
   localparam int unsigned MIX_W  = ADDR_W;
   localparam int unsigned PS_W   = $clog2(PRESCALE);

   logic [PS_W-1:0]     ps_q, ps_d;
   logic                tick;
   logic [PERIOD_W-1:0] period_q [NUM_CH];
   logic [PERIOD_W-1:0] period_d [NUM_CH];
   logic [NUM_CH-1:0]   tone_en_q, tone_en_d;
   logic [NUM_CH-1:0]   tone_w;
   logic                noise_bit;
   logic [MIX_W-1:0]    mix_q, mix_d;

   // Shared prescaler; tick marks the last count of each cycle.
   always_comb begin
      tick = (ps_q == PS_W'(PRESCALE - 1));
      ps_d = tick ? '0 : ps_q + PS_W'(1);
   end

   // Tone register file writes.
   always_comb begin
      period_d  = period_q;
      tone_en_d = tone_en_q;
      if (cfg_we) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_addr == ADDR_W'(i)) begin
               period_d[i] = cfg_wdata;
            end
         end
         if (cfg_addr == ADDR_W'(ADDR_CTRL(NUM_CH))) begin
            tone_en_d = cfg_wdata[NUM_CH-1:0];
         end
      end
   end

   // Prescaler and tone register state.
   always_ff @(posedge clk) begin
      if (rst) begin
         ps_q      <= '0;
         tone_en_q <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            period_q[i] <= '0;
         end
      end else begin
         ps_q      <= ps_d;
         tone_en_q <= tone_en_d;
         period_q  <= period_d;
      end
   end

   // Tone channels see the post-write enable so a disable on a tick mutes at once.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      audiogen_tone_ch #(.PERIOD_W(PERIOD_W)) u_ch (
         .clk      (clk),
         .rst      (rst),
         .tick     (tick),
         .en       (tone_en_d[g]),
         .period   (period_q[g]),
         .tone_out (tone_w[g])
      );
   end

`ifdef AUDIOGEN_NOISE_EN
   logic                noise_en_q, noise_en_d;
   logic [NRATE_W-1:0]  noise_rate_q, noise_rate_d;
   logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
   logic [NCNT_W-1:0]   ncnt_q, ncnt_d;
   logic [NCNT_W-1:0]   ncnt_lim;
   logic                noise_q, noise_d;

   // Noise registers, tick divider and LFSR advance.
   always_comb begin
      noise_en_d   = noise_en_q;
      noise_rate_d = noise_rate_q;
      lfsr_d       = lfsr_q;
      ncnt_d       = ncnt_q;
      ncnt_lim     = NCNT_W'((32'd1 << noise_rate_q) - 32'd1);
      if (cfg_we && (cfg_addr == ADDR_W'(ADDR_CTRL(NUM_CH)))) begin
         noise_en_d = cfg_wdata[NUM_CH];
      end
      if (cfg_we && (cfg_addr == ADDR_W'(ADDR_NRATE(NUM_CH)))) begin
         noise_rate_d = cfg_wdata[NRATE_W-1:0];
      end
      if (tick) begin
         if (ncnt_q == ncnt_lim) begin
            ncnt_d = '0;
            lfsr_d = lfsr_step(lfsr_q);
         end else begin
            ncnt_d = ncnt_q + NCNT_W'(1);
         end
      end
      noise_d = lfsr_d[0] & noise_en_d;
   end

   // Noise channel state.
   always_ff @(posedge clk) begin
      if (rst) begin
         noise_en_q   <= 1'b0;
         noise_rate_q <= '0;
         lfsr_q       <= LFSR_SEED;
         ncnt_q       <= '0;
         noise_q      <= 1'b0;
      end else begin
         noise_en_q   <= noise_en_d;
         noise_rate_q <= noise_rate_d;
         lfsr_q       <= lfsr_d;
         ncnt_q       <= ncnt_d;
         noise_q      <= noise_d;
      end
   end

   assign noise_bit = noise_q;
`else
   assign noise_bit = 1'b0;
`endif

   // Mixer: popcount of the current channel outputs.
   always_comb begin
      mix_d = MIX_W'(noise_bit);
      for (int i = 0; i < NUM_CH; i++) begin
         mix_d = mix_d + MIX_W'(tone_w[i]);
      end
   end

   // Mixer register.
   always_ff @(posedge clk) begin
      if (rst) begin
         mix_q <= '0;
      end else begin
         mix_q <= mix_d;
      end
   end

   assign tone_out  = tone_w;
   assign noise_out = noise_bit;
   assign mix_level = mix_q;

endmodule
